// File: rtl/key_recorder.sv
// Key record/playback stage feeding the buzzer.
// Captures (note, octave, duration) entries and replays them on demand.
module key_recorder #(
  parameter int DEPTH    = 32,
  parameter int TICK_DIV = 5_000_000,
  parameter int DUR_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [6:0]               keys,
  input  logic [1:0]               octave,
  input  logic                     write_on,
  input  logic                     play,
  output logic [3:0]               note_out,
  output logic [1:0]               octave_out,
  output logic                     busy,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IW    = $clog2(DEPTH);
  localparam int CW    = IW + 1;
  localparam int DIV_W = $clog2(TICK_DIV + 1);
  localparam int EW    = 6 + DUR_W;
  localparam logic [DUR_W-1:0] DMAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REC,
    S_PLAY
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [EW-1:0]    r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_busy;
  logic [3:0]       r_note;
  logic [1:0]       r_oct;
  logic [DIV_W-1:0] r_div;
  logic             r_wr_d;
  logic [5:0]       r_ekey;
  logic [DUR_W-1:0] r_edur;
  logic [IW-1:0]    r_idx;
  logic [DUR_W-1:0] r_rem;

  logic [3:0]       w_cur_note;
  logic [5:0]       w_cur_key;
  logic             w_tick;
  logic             w_rise;
  logic             w_fall;
  logic             w_lead;
  logic             w_chg;
  logic [DUR_W-1:0] w_edur_t;
  logic             w_wr;
  logic             w_reopen;
  logic             w_last;
  logic [IW-1:0]    w_rd_addr;
  logic [EW-1:0]    w_rd;

  // Lowest-indexed pressed key wins.
  always_comb begin
    w_cur_note = 4'd0;
    for (int i = 6; i >= 0; i--) begin
      if (keys[i]) w_cur_note = 4'(i + 1);
    end
  end

  assign w_cur_key = {w_cur_note, octave};
  assign w_tick    = (r_div == DIV_W'(TICK_DIV - 1));
  assign w_rise    = write_on & ~r_wr_d;
  assign w_fall    = ~write_on & r_wr_d;
  assign w_lead    = (r_count == '0) && (r_ekey[5:2] == 4'd0);
  assign w_chg     = (w_cur_key != r_ekey);
  // Tick is credited to the open entry before any write decision.
  assign w_edur_t  = w_lead ? '0 : r_edur + DUR_W'(w_tick);
  assign w_last    = (r_idx == IW'(r_count - CW'(1)));
  assign w_rd_addr = (r_state == S_PLAY) ? r_idx + IW'(1) : '0;
  assign w_rd      = r_mem[w_rd_addr];

  always_comb begin
    w_nxt    = r_state;
    w_wr     = 1'b0;
    w_reopen = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) w_nxt = S_REC;
        else if (play && r_count != '0) w_nxt = S_PLAY;
      end
      S_REC: begin
        if (w_fall) begin
          w_wr  = (w_edur_t != '0) && (r_ekey[5:2] != 4'd0);
          w_nxt = S_IDLE;
        end else if (w_chg) begin
          w_wr     = (w_edur_t != '0);
          w_reopen = 1'b1;
        end else if (w_edur_t == DMAX) begin
          w_wr     = 1'b1;
          w_reopen = 1'b1;
        end
        if (w_wr && r_count == CW'(DEPTH - 1)) w_nxt = S_IDLE;
      end
      S_PLAY: begin
        if (play) w_nxt = S_IDLE;
        else if (w_tick && r_rem == DUR_W'(1) && w_last) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset && r_state == S_REC && w_wr) begin
      r_mem[r_count[IW-1:0]] <= {r_ekey, w_edur_t};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_full  <= 1'b0;
      r_busy  <= 1'b0;
      r_note  <= 4'd0;
      r_oct   <= 2'd0;
      r_div   <= '0;
      r_wr_d  <= 1'b0;
      r_ekey  <= '0;
      r_edur  <= '0;
      r_idx   <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_nxt;
      r_busy  <= (w_nxt != S_IDLE);
      r_wr_d  <= write_on;
      r_div   <= (w_nxt != r_state || w_tick) ? '0 : r_div + DIV_W'(1);
      r_note  <= 4'd0;
      r_oct   <= 2'd0;
      case (r_state)
        S_IDLE: begin
          if (w_nxt == S_REC) begin
            r_count <= '0;
            r_full  <= 1'b0;
            r_ekey  <= w_cur_key;
            r_edur  <= '0;
            r_note  <= w_cur_note;
            r_oct   <= octave;
          end else if (w_nxt == S_PLAY) begin
            r_idx  <= '0;
            r_note <= w_rd[EW-1 -: 4];
            r_oct  <= w_rd[DUR_W+1 -: 2];
            r_rem  <= w_rd[DUR_W-1:0];
          end
        end
        S_REC: begin
          if (w_wr) begin
            r_count <= r_count + CW'(1);
            if (r_count == CW'(DEPTH - 1)) r_full <= 1'b1;
          end
          if (w_reopen) begin
            r_ekey <= w_cur_key;
            r_edur <= '0;
          end else begin
            r_edur <= w_edur_t;
          end
          if (w_nxt == S_REC) begin
            r_note <= w_cur_note;
            r_oct  <= octave;
          end
        end
        S_PLAY: begin
          if (w_nxt == S_PLAY) begin
            r_note <= r_note;
            r_oct  <= r_oct;
            if (w_tick) begin
              if (r_rem == DUR_W'(1)) begin
                r_idx  <= w_rd_addr;
                r_note <= w_rd[EW-1 -: 4];
                r_oct  <= w_rd[DUR_W+1 -: 2];
                r_rem  <= w_rd[DUR_W-1:0];
              end else begin
                r_rem <= r_rem - DUR_W'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign note_out   = r_note;
  assign octave_out = r_oct;
  assign busy       = r_busy;
  assign full       = r_full;
  assign count      = r_count;

endmodule

// File: doc/key_recorder.md
Name: key_recorder

Overview:
- Record/playback stage directly upstream of the Buzzer.
- While write_on is high, captures live key presses into an on-chip note buffer as (note, octave, duration) entries.
- On a play pulse, replays the buffer as a timed note/octave stream on the same 4-bit note and 2-bit octave format the Buzzer consumes.
- Outside recording and playback, the outputs are silent (note 0).

Parameters:
- DEPTH, 32: number of buffer entries. Power of two, 2..256.
- TICK_DIV, 5_000_000: clk cycles per duration unit (50 ms at 100 MHz).
- DUR_W, 8: duration field width. Maximum duration is 2^DUR_W-1 units.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- keys  in  7  piano keys, already debounced, 1 = pressed
- octave  in  2  live octave select, stored with each entry
- write_on  in  1  level; high = record session
- play  in  1  debounced single-cycle pulse; starts or aborts playback
- note_out  out  4  0 = rest, 1..7 = do..si; registered
- octave_out  out  2  octave for note_out; registered
- busy  out  1  high in REC or PLAY
- full  out  1  buffer holds DEPTH entries
- count  out  log2(DEPTH)+1  number of stored entries

Behaviour:
- Reset (reset==0 at a clk edge):
  - State = IDLE; count = 0; full = 0; note_out = 0; octave_out = 0; busy = 0.
  - Tick divider = 0.
  - Buffer contents are don't-care.
- Key encoding (combinational, cur_note):
  - The lowest-indexed pressed key wins: keys[0] -> 1, ..., keys[6] -> 7.
  - No key pressed -> 0.
  - cur_key = {cur_note, octave}.
- Tick: the divider counts 0..TICK_DIV-1 and tick=1 on the cycle it equals TICK_DIV-1. The divider clears on every state entry.
- IDLE:
  - note_out = 0.
  - write_on rising edge (registered compare) -> REC. This clears count and full, and buffer history is lost.
  - play with count > 0 -> PLAY.
  - play with count == 0 is ignored.
  - If the write_on rise and play occur in the same cycle, REC wins.
- REC:
  - note_out/octave_out follow cur_key with 1-cycle latency (monitor).
  - Open entry {ekey, edur}. On REC entry, ekey = cur_key and edur = 0.
  - Each tick: edur increments.
  - Leading rest: while count == 0 and ekey.note == 0, edur is held at 0 (leading rest discarded).
  - cur_key != ekey at an edge:
    - If edur >= 1, write {ekey, edur} to mem[count] and increment count.
    - Otherwise discard (sub-unit glitch filter).
    - In both cases open a new entry with ekey = cur_key, edur = 0.
  - Tick and key change in the same cycle: the tick is credited to the old entry first, then the write is evaluated.
  - edur reaching 2^DUR_W-1: write the entry and reopen the same key with edur = 0.
  - count reaching DEPTH: full = 1 -> IDLE. Further keys are ignored until a new write_on rise.
  - write_on falling edge: flush the open entry if edur >= 1 and note != 0 (a trailing rest is dropped) -> IDLE.
  - play is ignored in REC.
- PLAY:
  - idx = 0. On the edge after play is sampled: note_out/octave_out = mem[0] key, rem = mem[0] dur.
  - Each tick: rem decrements. When rem reaches 0, idx increments and the next entry loads on the same edge.
  - Each entry is therefore held for exactly dur*TICK_DIV cycles; there is no gap cycle between entries.
  - After the last entry (idx == count-1) expires -> IDLE, note_out = 0.
  - play during PLAY aborts: next edge -> IDLE, note_out = 0.
  - write_on changes are ignored during PLAY, and the edge detector tracks them. Recording requires a fresh rise in IDLE.
- busy = (state != IDLE), registered with the state.
- Reset mid-REC or mid-PLAY: immediate return to the reset values on that edge, and count clears.

Test Plan (TICK_DIV = 4, DEPTH = 8):
1. Reset low for 2 cycles -> all outputs 0, busy = 0. play pulse while count = 0 -> state stays IDLE.
2. write_on=1; keys=0 for 8 cycles; keys[2] for 12 cycles; keys[4] for 8 cycles; write_on=0 -> count = 2. Entries are {3,oct,3} and {5,oct,2}; the leading rest is not stored.
3. After scenario 2, pulse play -> note_out = 3 from the next edge for 12 cycles, then 5 for 8 cycles, then 0, busy = 0. octave_out matches the recorded octave throughout.
4. Record with key toggles of 2-cycle width (< 1 tick) between two 8-cycle notes -> the glitches are dropped and count = 2.
5. Record 9 distinct 4-cycle notes with alternating keys -> full = 1 and busy = 0 after the 8th write. The 9th note is not stored and count = 8.
6. Mid-playback play pulse -> note_out = 0 on the next edge. Separately, reset asserted mid-REC -> count = 0 and IDLE on that edge.
